// File: rtl/inst_fetch_mem.sv
// inst_fetch_mem: halfword-organised instruction memory with a registered
// read port behind a valid/ready request/response handshake. A fetch returns
// FETCH_HALVES consecutive halfwords, lowest address in the least-significant
// slot. Out-of-range fetches respond with rsp_err=1 and zero data.
// A halfword write port preloads the program store.
// Optional build macro IFM_PERF_CNT_EN adds saturating fetch/stall counters.
module inst_fetch_mem #(
    parameter int ADDR_W       = 20,
    parameter int HALF_W       = 16,
    parameter int DEPTH_LOG2   = 10,
    parameter int FETCH_HALVES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDR_W-1:0]              req_addr,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [FETCH_HALVES*HALF_W-1:0] rsp_data,
    output logic                           rsp_err,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [HALF_W-1:0]              wr_data
`ifdef IFM_PERF_CNT_EN
    ,
    output logic [31:0]                    perf_fetches,
    output logic [31:0]                    perf_stalls
`endif
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int FW     = FETCH_HALVES * HALF_W;

    // Address comparisons use one extra bit so the top of the space never wraps.
    localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] SPAN_M1   = (ADDR_W+1)'(FETCH_HALVES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESP  = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t            state;
    logic [HALF_W-1:0] mem [DEPTH];

    logic              accept;
    logic [ADDR_W:0]   last_addr;
    logic              rd_in_range;
    logic              wr_in_range;
    logic [FW-1:0]     fetch_word;

    // A new request may enter whenever the output slot is empty or draining.
    assign req_ready   = !rsp_valid || rsp_ready;
    assign accept      = req_valid && req_ready;

    assign last_addr   = {1'b0, req_addr} + SPAN_M1;
    assign rd_in_range = (last_addr <= LAST_IDX);
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);

    // Gather the fetch word from the array; the range check guarantees no wrap.
    always_comb begin
        fetch_word = '0;
        if (rd_in_range) begin
            for (int k = 0; k < FETCH_HALVES; k++) begin
                fetch_word[k*HALF_W +: HALF_W] =
                    mem[DEPTH_LOG2'(req_addr[DEPTH_LOG2-1:0] + DEPTH_LOG2'(k))];
            end
        end
    end

    // Preload port; out-of-range and reset-coincident writes are dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_en && wr_in_range) begin
            mem[wr_addr[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    // Response FSM: captures the read on accept and holds it while refused.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= fetch_word;
                        rsp_err   <= !rd_in_range;
                    end
                end
                RESP, STALL: begin
                    if (accept) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= fetch_word;
                        rsp_err   <= !rd_in_range;
                    end else if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end else begin
                        state     <= STALL;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFM_PERF_CNT_EN
    // Saturating counters of accepted fetches and refused-response cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetches <= '0;
            perf_stalls  <= '0;
        end else begin
            if (accept && (perf_fetches != 32'hFFFF_FFFF)) begin
                perf_fetches <= perf_fetches + 32'd1;
            end
            if (rsp_valid && !rsp_ready && (perf_stalls != 32'hFFFF_FFFF)) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/inst_fetch_mem.md
Name: inst_fetch_mem

Overview:
Parametrised instruction memory with a registered read port and a valid/ready request/response handshake. It returns one fetch word built from FETCH_HALVES consecutive halfwords starting at a halfword address; the lowest address sits in the least-significant slot. It sits between the fetch stage and the program store, and has a halfword write port for program preload by the testbench or a loader. It adds backpressure, bounds checking and preload to the earlier combinational instruction memory.

Parameters:
ADDR_W, 20, width of the halfword address.
HALF_W, 16, bits per memory halfword.
DEPTH_LOG2, 10, log2 of the number of halfwords stored (DEPTH = 2**DEPTH_LOG2).
FETCH_HALVES, 2, halfwords concatenated per fetch word; legal range 1..4.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous reset, active-high.
req_valid  in  1  fetch request present.
req_ready  out  1  block can accept a request this cycle.
req_addr  in  ADDR_W  halfword address of the first halfword.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts the response this cycle.
rsp_data  out  FETCH_HALVES*HALF_W  fetched word, {M[a+F-1],...,M[a+1],M[a]}.
rsp_err  out  1  request was out of range; qualified by rsp_valid.
wr_en  in  1  preload write strobe.
wr_addr  in  ADDR_W  halfword write address.
wr_data  in  HALF_W  halfword write data.

Behaviour:
- One clock domain (clk). Synchronous active-high reset (rst).
- Reset values: rsp_valid=0, rsp_data=0, rsp_err=0, state=IDLE, req_ready=1 in the cycle after reset. Memory contents are not reset.
- States:
  - IDLE: no response held.
  - RESP: response presented.
  - STALL: response presented and previously refused.
- Request accept: req_valid && req_ready at edge N. rsp_valid=1 from edge N+1 with data captured at edge N. Latency is 1 cycle.
- req_ready = !rsp_valid || rsp_ready. This is the combinational pass-through, so back-to-back fetches sustain 1 per cycle.
- Transitions:
  - IDLE -> RESP on accept.
  - RESP -> RESP on accept with rsp_ready.
  - RESP -> IDLE on rsp_ready without a new accept.
  - RESP -> STALL on !rsp_ready.
  - STALL -> RESP/IDLE by the same rules as RESP.
- In STALL, rsp_data and rsp_err hold constant. The memory is not re-read, so a write to the fetched address while stalled does not change the held response.
- Range check: the request is in range iff req_addr + FETCH_HALVES - 1 <= DEPTH - 1. Compute with ADDR_W+1 bits, so there is no wrap at the top of the address space.
  - Out of range: rsp_err=1, rsp_data=0, and the response is delivered with normal handshake/latency.
  - No wrap-around to halfword 0, ever.
- Writes: when wr_en=1, M[wr_addr] <= wr_data at the edge. If wr_addr >= DEPTH, the write is ignored silently. Writes are independent of the handshake and allowed in any state.
- Same-edge write and accepted read overlapping the write address: the read returns the OLD data (read-before-write).
- rst asserted mid-response: the response is discarded, rsp_valid=0 next cycle, and an in-flight accept is dropped. A wr_en coincident with rst is ignored.
- Unaligned addresses (odd req_addr with FETCH_HALVES=2) are legal; no alignment check.

Optional Feature:
Macro IFM_PERF_CNT_EN.
- Defined: adds outputs perf_fetches (32 bits) and perf_stalls (32 bits), both synchronously cleared by rst.
  - perf_fetches increments on each accepted request.
  - perf_stalls increments on each cycle with rsp_valid && !rsp_ready.
  - Both saturate at all-ones; no wrap.
- Undefined: the ports and counters are absent. The remaining behaviour is bit-identical.

Test Plan:
1. Preload M[0]=16'h1111, M[1]=16'h2222, M[2]=16'h3333. Request addr 0 with rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=32'h2222_1111, rsp_err=0.
2. Request addr 1 -> rsp_data=32'h3333_2222 (unaligned fetch).
3. Requests on three consecutive cycles at 0, 1, 2 with rsp_ready=1 -> req_ready stays 1 and responses appear on consecutive cycles in order.
4. Backpressure: accept addr 0, hold rsp_ready=0 for 3 cycles, and write M[0]=16'hAAAA during the stall -> req_ready=0, rsp_data held at 32'h2222_1111, then released on rsp_ready=1. With IFM_PERF_CNT_EN: perf_stalls=3, perf_fetches=1.
5. Range check: request addr 1023 (DEPTH=1024) and addr 20'hFFFFF -> rsp_err=1, rsp_data=0, no wrap to M[0].
6. Same-edge write M[4]=16'hBEEF with request addr 4 (old M[4]=16'h0004, M[5]=16'h0005) -> rsp_data=32'h0005_0004. A repeat request returns 32'h0005_BEEF. Assert rst while rsp_valid=1 -> rsp_valid=0 next cycle.
